irrigation_sequencer: RTL and testbench

- Master FSM for the irrigation timer: generates the two-bit mode code (ff1, ff2) consumed by the per-mode phase counters, and advances phases on their terminal-count flag.
- Sequence per cycle: fill -> drip or spray -> optional clean (every CLEAN_EVERY cycles) -> idle.
- Owns the fill-timeout watchdog and the irrigation-cycle counter.
- Drives the phase-counter enable and load pulse.

---
 rtl/irrig_pkg.sv | 38 +++
 rtl/rise_detect.sv | 25 ++
 rtl/irrigation_sequencer.sv | 127 ++++++++++++
 tb/tb_irrigation_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrig_pkg.sv
// rtl/irrig_pkg.sv - shared state, mode codes and output decode for the irrigation sequencer
package irrig_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    IRRIG = 3'd2,
    CLEAN = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] MODE_FILL  = 2'b00;
  localparam logic [1:0] MODE_DRIP  = 2'b01;
  localparam logic [1:0] MODE_SPRAY = 2'b10;
  localparam logic [1:0] MODE_CLEAN = 2'b11;

  typedef struct packed {
    logic [1:0] mode;
    logic       run;
    logic       busy;
    logic       fault;
  } outs_t;

  // Registered output image of a state; IDLE and FAULT park the mode code at 00.
  function automatic outs_t decode(state_t s, logic sel);
    outs_t o;
    o = '0;
    case (s)
      FILL:    begin o.mode = MODE_FILL;  o.run = 1'b1; o.busy = 1'b1; end
      IRRIG:   begin o.mode = sel ? MODE_SPRAY : MODE_DRIP; o.run = 1'b1; o.busy = 1'b1; end
      CLEAN:   begin o.mode = MODE_CLEAN; o.run = 1'b1; o.busy = 1'b1; end
      FAULT:   o.fault = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for the start request
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic start_rise
);

  logic start_q;
  logic armed;

  // armed stays low for the first clock after reset so a level already high is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      start_q <= start;
      armed   <= 1'b1;
    end
  end

  assign start_rise = start & ~start_q & armed;

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - master FSM: fill, drip/spray, periodic clean, fill watchdog
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int FILL_TIMEOUT = 1000,
  parameter int CLEAN_EVERY  = 3,
  parameter int TO_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       spray_sel,
  input  logic       tank_full,
  input  logic       phase_done,
  input  logic       abort,
  input  logic       fault_clr,
  output logic       ff1,
  output logic       ff2,
  output logic       run,
  output logic       phase_start,
  output logic       busy,
  output logic       fault,
  output logic       cycle_done,
  output logic [3:0] cycle_cnt
);

  localparam logic [TO_W-1:0] WD_LAST   = TO_W'(FILL_TIMEOUT - 1);
  localparam logic [3:0]      CLEAN_CNT = 4'(CLEAN_EVERY);

  state_t          state;
  outs_t           outs;
  logic [TO_W-1:0] watchdog;
  logic            sel_q;
  logic            start_rise;

  rise_detect u_rise (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_rise (start_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outs        <= '0;
      phase_start <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_cnt   <= 4'd0;
      watchdog    <= '0;
      sel_q       <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      cycle_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= FILL;
            outs        <= decode(FILL, spray_sel);
            phase_start <= 1'b1;
            watchdog    <= '0;
            sel_q       <= spray_sel;
          end
        end
        FILL: begin
          watchdog <= watchdog + 1'b1;
          if (abort) begin
            state <= IDLE;
            outs  <= decode(IDLE, sel_q);
          end else if (tank_full) begin
            state       <= IRRIG;
            outs        <= decode(IRRIG, sel_q);
            phase_start <= 1'b1;
          end else if (watchdog == WD_LAST) begin
            state <= FAULT;
            outs  <= decode(FAULT, sel_q);
          end
        end
        IRRIG: begin
          if (abort) begin
            state <= IDLE;
            outs  <= decode(IDLE, sel_q);
          end else if (phase_done) begin
            if (cycle_cnt + 4'd1 == CLEAN_CNT) begin
              cycle_cnt   <= 4'd0;
              state       <= CLEAN;
              outs        <= decode(CLEAN, sel_q);
              phase_start <= 1'b1;
            end else begin
              cycle_cnt  <= cycle_cnt + 4'd1;
              state      <= IDLE;
              outs       <= decode(IDLE, sel_q);
              cycle_done <= 1'b1;
            end
          end
        end
        CLEAN: begin
          if (abort) begin
            state <= IDLE;
            outs  <= decode(IDLE, sel_q);
          end else if (phase_done) begin
            state      <= IDLE;
            outs       <= decode(IDLE, sel_q);
            cycle_done <= 1'b1;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state <= IDLE;
            outs  <= decode(IDLE, sel_q);
          end
        end
        default: begin
          state <= IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign ff1   = outs.mode[0];
  assign ff2   = outs.mode[1];
  assign run   = outs.run;
  assign busy  = outs.busy;
  assign fault = outs.fault;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - scoreboard bench for irrigation_sequencer
module tb_irrigation_sequencer;

  localparam int FT = 8;
  localparam int CE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, spray_sel, tank_full, phase_done, abort, fault_clr;
  logic       ff1, ff2, run, phase_start, busy, fault, cycle_done;
  logic [3:0] cycle_cnt;

  irrigation_sequencer #(.FILL_TIMEOUT(FT), .CLEAN_EVERY(CE), .TO_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .spray_sel   (spray_sel),
    .tank_full   (tank_full),
    .phase_done  (phase_done),
    .abort       (abort),
    .fault_clr   (fault_clr),
    .ff1         (ff1),
    .ff2         (ff2),
    .run         (run),
    .phase_start (phase_start),
    .busy        (busy),
    .fault       (fault),
    .cycle_done  (cycle_done),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef enum int {M_IDLE, M_FILL, M_IRRIG, M_CLEAN, M_FAULT} mstate_t;
  mstate_t     m_state;
  int          m_wd;
  int          m_cnt;
  logic        m_sel;
  logic        m_startq;
  logic [10:0] exp_q[$];

  function automatic logic [10:0] dut_vec();
    return {ff2, ff1, run, phase_start, busy, fault, cycle_done, cycle_cnt};
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_wd     = 0;
    m_cnt    = 0;
    m_sel    = 1'b0;
    m_startq = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic       rise, ps, cd, act;
    logic [1:0] mode;
    mstate_t    ns;
    rise     = start & ~m_startq;
    m_startq = start;
    ps = 1'b0;
    cd = 1'b0;
    ns = m_state;
    case (m_state)
      M_IDLE:  if (rise) begin ns = M_FILL; m_sel = spray_sel; m_wd = 0; ps = 1'b1; end
      M_FILL: begin
        if (abort) ns = M_IDLE;
        else if (tank_full) begin ns = M_IRRIG; ps = 1'b1; end
        else if (m_wd == FT - 1) ns = M_FAULT;
        else m_wd++;
      end
      M_IRRIG: begin
        if (abort) ns = M_IDLE;
        else if (phase_done) begin
          if (m_cnt + 1 == CE) begin m_cnt = 0; ns = M_CLEAN; ps = 1'b1; end
          else begin m_cnt++; ns = M_IDLE; cd = 1'b1; end
        end
      end
      M_CLEAN: begin
        if (abort) ns = M_IDLE;
        else if (phase_done) begin ns = M_IDLE; cd = 1'b1; end
      end
      M_FAULT: if (fault_clr) ns = M_IDLE;
      default: ns = M_IDLE;
    endcase
    m_state = ns;
    act  = (ns == M_FILL) || (ns == M_IRRIG) || (ns == M_CLEAN);
    mode = (ns == M_IRRIG) ? (m_sel ? 2'b10 : 2'b01) : (ns == M_CLEAN) ? 2'b11 : 2'b00;
    exp_q.push_back({mode, act, ps, act, (ns == M_FAULT), cd, 4'(m_cnt)});
  endtask

  task automatic cyc(input string tag);
    logic [10:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(dut_vec()), 32'(e));
    end
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic kick(input logic sel);
    spray_sel = sel;
    start = 1'b1;
    cyc("fill_entry");
    check("fill_phase_start", 32'({phase_start, busy, ff2, ff1}), 32'b1100);
    start = 1'b0;
  endtask

  task automatic fill_to_irrig(input int waits);
    cycles(waits, "fill_wait");
    tank_full = 1'b1;
    cyc("irrig_entry");
    tank_full = 1'b0;
    check("irrig_phase_start", 32'({phase_start, run}), 32'b11);
  endtask

  task automatic finish_irrig(input int waits);
    cycles(waits, "irrig_wait");
    phase_done = 1'b1;
    cyc("irrig_done");
    phase_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1; spray_sel = 1'b0; tank_full = 1'b0;
    phase_done = 1'b0; abort = 1'b0; fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec()), 32'd0);

    // start held high across reset release must not trigger
    rst_n = 1'b1;
    cycles(4, "start_held");
    check("start_held_idle", 32'(busy), 32'd0);
    start = 1'b0;
    cyc("start_low");

    // drip cycle with start glitches during FILL and spray_sel toggling during IRRIG
    kick(1'b0);
    cyc("fill_a");
    start = 1'b1; cyc("fill_start_ignored");
    start = 1'b0; cyc("fill_b");
    fill_to_irrig(1);
    check("drip_mode", 32'({ff2, ff1}), 32'b01);
    spray_sel = 1'b1; cycles(3, "irrig_sel_toggle");
    check("drip_mode_held", 32'({ff2, ff1}), 32'b01);
    spray_sel = 1'b0;
    finish_irrig(10);
    check("drip_cycle_done", 32'({cycle_done, cycle_cnt}), 32'h11);
    cyc("idle_after_drip");

    // two spray cycles: second reaches CLEAN_EVERY and inserts CLEAN
    kick(1'b1);
    fill_to_irrig(2);
    check("spray_mode", 32'({ff2, ff1}), 32'b10);
    finish_irrig(3);
    check("spray_cnt2", 32'(cycle_cnt), 32'd2);
    kick(1'b1);
    fill_to_irrig(0);
    finish_irrig(2);
    check("clean_entry", 32'({ff2, ff1, phase_start, cycle_done, cycle_cnt}), 32'b11_1_0_0000);
    cycles(3, "clean_wait");
    phase_done = 1'b1; cyc("clean_done"); phase_done = 1'b0;
    check("clean_cycle_done", 32'({cycle_done, busy}), 32'b10);

    // one drip to make cycle_cnt nonzero, then fill timeout
    kick(1'b0);
    fill_to_irrig(0);
    finish_irrig(1);
    kick(1'b0);
    cycles(FT - 1, "timeout_wait");
    check("timeout_not_yet", 32'({fault, busy}), 32'b01);
    cyc("timeout_edge");
    check("fault_state", 32'({fault, run, ff2, ff1}), 32'b1000);
    abort = 1'b1; phase_done = 1'b1; tank_full = 1'b1; cycles(2, "fault_ignores");
    abort = 1'b0; phase_done = 1'b0; tank_full = 1'b0;
    fault_clr = 1'b1; cyc("fault_clr"); fault_clr = 1'b0;
    check("fault_clr_cnt", 32'({fault, cycle_cnt}), 32'h01);

    // abort beats phase_done and tank_full in IRRIG
    kick(1'b1);
    fill_to_irrig(1);
    abort = 1'b1; phase_done = 1'b1; tank_full = 1'b1;
    cyc("abort_irrig");
    abort = 1'b0; phase_done = 1'b0; tank_full = 1'b0;
    check("abort_result", 32'({busy, cycle_done, cycle_cnt}), 32'h01);

    // tank_full coincident with watchdog terminal count wins
    kick(1'b0);
    fill_to_irrig(FT - 1);
    check("tank_wins", 32'({fault, ff2, ff1}), 32'b001);
    finish_irrig(1);
    check("cnt_after_tank_wins", 32'(cycle_cnt), 32'd2);

    // enter CLEAN then async reset between edges
    kick(1'b0);
    fill_to_irrig(0);
    finish_irrig(0);
    cyc("clean_hold");
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    m_startq = 1'b0;
    #1 rst_n = 1'b1;
    cyc("post_reset_idle");
    kick(1'b1);
    fill_to_irrig(1);
    finish_irrig(2);
    check("post_reset_cycle", 32'({cycle_done, cycle_cnt}), 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
